ps2_mouse_dev_tx: RTL and testbench

PS/2 device-side mouse emulator. It accepts a movement/button sample from local logic and encodes it as a standard 3-byte mouse packet. It then transmits the packet on the PS/2 bus as the device: the block generates ps2c itself and drives open-collector ps2c/ps2d. It is the counterpart of the host-side mouse receiver and is used to drive host logic or a host port in loopback tests.

---
 rtl/ps2_mouse_dev_tx_pkg.sv | 63 ++++++
 rtl/ps2_mouse_dev_tx_byte.sv | 125 ++++++++++++
 rtl/ps2_mouse_dev_tx.sv | 165 ++++++++++++++++
 tb/tb_ps2_mouse_dev_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_dev_tx_pkg.sv
// Shared types, constants and packet helpers for the PS/2 device-side mouse transmitter.
package ps2_mouse_dev_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_TX_HIGH,
        ST_TX_LOW,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int FRAME_BITS = 11;

    localparam int B0_BTN_L  = 0;
    localparam int B0_BTN_R  = 1;
    localparam int B0_BTN_M  = 2;
    localparam int B0_ONE    = 3;
    localparam int B0_X_SIGN = 4;
    localparam int B0_Y_SIGN = 5;
    localparam int B0_X_OVF  = 6;
    localparam int B0_Y_OVF  = 7;

    localparam logic signed [9:0] SAT_MAX = 10'sd255;
    localparam logic signed [9:0] SAT_MIN = -10'sd256;

    // Returns {ovf, value[8:0]} clamped to the 9-bit packet range.
    function automatic logic [9:0] saturate(input logic [9:0] v);
        if ($signed(v) > SAT_MAX) begin
            saturate = {1'b1, 9'h0FF};
        end else if ($signed(v) < SAT_MIN) begin
            saturate = {1'b1, 9'h100};
        end else begin
            saturate = {1'b0, v[8:0]};
        end
    endfunction

    // Packet layout: [7:0] byte0, [15:8] byte1, [23:16] byte2.
    function automatic logic [23:0] build_packet(input logic [9:0] x, input logic [9:0] y,
                                                 input logic [2:0] btn);
        logic [9:0] xs;
        logic [9:0] ys;
        logic [7:0] b0;
        xs = saturate(x);
        ys = saturate(y);
        b0 = 8'h00;
        b0[B0_BTN_L]  = btn[0];
        b0[B0_BTN_R]  = btn[1];
        b0[B0_BTN_M]  = btn[2];
        b0[B0_ONE]    = 1'b1;
        b0[B0_X_SIGN] = xs[8];
        b0[B0_Y_SIGN] = ys[8];
        b0[B0_X_OVF]  = xs[9];
        b0[B0_Y_OVF]  = ys[9];
        build_packet = {ys[7:0], xs[7:0], b0};
    endfunction

    // Start bit, data LSB first, odd parity, stop bit.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
        make_frame = {1'b1, ~(^d), d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_mouse_dev_tx_byte.sv
// Sends one 11-bit device frame on the PS/2 bus, generating the clock and
// aborting when the host holds the clock low at the end of a high phase.
module ps2_dev_byte_tx
    import ps2_mouse_dev_tx_pkg::*;
#(
    parameter int CLK_HALF = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       c_sync,
    output logic       c_low,
    output logic       d_low,
    output logic       done,
    output logic       abort
);

    localparam int CW = $clog2(CLK_HALF + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    // Only ST_IDLE, ST_TX_HIGH and ST_TX_LOW are used here.
    state_t                 state_r, state_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [3:0]             bit_r, bit_s;
    logic [FRAME_BITS-1:0]  frame_r, frame_s;
    logic                   c_low_r, c_low_s;
    logic                   d_low_r, d_low_s;
    logic                   done_r, done_s;
    logic                   abort_r, abort_s;

    // Frame state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 4'd0;
            frame_r <= {FRAME_BITS{1'b0}};
            c_low_r <= 1'b0;
            d_low_r <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            frame_r <= frame_s;
            c_low_r <= c_low_s;
            d_low_r <= d_low_s;
            done_r  <= done_s;
            abort_r <= abort_s;
        end
    end

    // Phase sequencing, line drive and inhibit check.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        frame_s = frame_r;
        c_low_s = c_low_r;
        d_low_s = d_low_r;
        done_s  = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                c_low_s = 1'b0;
                if (start) begin
                    frame_s = make_frame(data);
                    state_s = ST_TX_HIGH;
                    cnt_s   = {CW{1'b0}};
                    bit_s   = 4'd0;
                    d_low_s = ~frame_s[0];
                end else begin
                    d_low_s = 1'b0;
                end
            end
            ST_TX_HIGH: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (c_sync) begin
                        state_s = ST_TX_LOW;
                        c_low_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        c_low_s = 1'b0;
                        d_low_s = 1'b0;
                        abort_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_TX_LOW: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    c_low_s = 1'b0;
                    if (bit_r == LAST_BIT) begin
                        state_s = ST_IDLE;
                        d_low_s = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        bit_s   = bit_r + 4'd1;
                        state_s = ST_TX_HIGH;
                        d_low_s = ~frame_r[bit_s];
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                c_low_s = 1'b0;
                d_low_s = 1'b0;
            end
        endcase
    end

    assign c_low = c_low_r;
    assign d_low = d_low_r;
    assign done  = done_r;
    assign abort = abort_r;

endmodule

// File: rtl/ps2_mouse_dev_tx.sv
// PS/2 device-side mouse emulator: saturates a movement sample, builds the
// 3-byte packet and sends it byte by byte, restarting the packet on inhibit.
module ps2_mouse_dev_tx
    import ps2_mouse_dev_tx_pkg::*;
#(
    parameter int CLK_HALF = 1000,
    parameter int IDLE_CYC = 2500,
    parameter int GAP_CYC  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        ps2c,
    inout  wire        ps2d,
    input  logic [9:0] xm,
    input  logic [9:0] ym,
    input  logic [2:0] btnm,
    input  logic       wr_pkt,
    output logic       ready,
    output logic       done_tick,
    output logic       retry_tick
);

    localparam int CNT_MAX = (IDLE_CYC > GAP_CYC) ? IDLE_CYC : GAP_CYC;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    // ST_TX_HIGH here means "a frame is in flight in the byte sender".
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    idx_r, idx_s;
    logic [23:0]   pkt_r, pkt_s;
    logic          ready_r, done_r, retry_r;
    logic          c_meta_r, c_sync_r, d_meta_r, d_sync_r;
    logic          start_s;
    logic [7:0]    byte_s;
    logic          tx_c_low, tx_d_low, tx_done, tx_abort;

    // Bus synchronizers and packet-level registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            c_meta_r <= 1'b1;
            c_sync_r <= 1'b1;
            d_meta_r <= 1'b1;
            d_sync_r <= 1'b1;
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            idx_r    <= 2'd0;
            pkt_r    <= 24'h000000;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            retry_r  <= 1'b0;
        end else begin
            c_meta_r <= ps2c;
            c_sync_r <= c_meta_r;
            d_meta_r <= ps2d;
            d_sync_r <= d_meta_r;
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            pkt_r    <= pkt_s;
            ready_r  <= (state_s == ST_IDLE);
            done_r   <= (state_s == ST_DONE);
            retry_r  <= tx_abort;
        end
    end

    // Packet sequencing: handshake, bus-idle wait, byte index and gap.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        pkt_s   = pkt_r;
        start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_s = 2'd0;
                cnt_s = {CW{1'b0}};
                if (wr_pkt) begin
                    pkt_s   = build_packet(xm, ym, btnm);
                    state_s = ST_WAIT_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (c_sync_r && d_sync_r) begin
                    if (cnt_r == IDLE_LAST) begin
                        start_s = 1'b1;
                        cnt_s   = {CW{1'b0}};
                        state_s = ST_TX_HIGH;
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_s = {CW{1'b0}};
                end
            end
            ST_TX_HIGH: begin
                if (tx_abort) begin
                    idx_s   = 2'd0;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_WAIT_IDLE;
                end else if (tx_done) begin
                    cnt_s = {CW{1'b0}};
                    if (idx_r == 2'd2) begin
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = ST_GAP;
                    end
                end else begin
                    state_s = ST_TX_HIGH;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_WAIT_IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Select the packet byte currently being sent.
    always_comb begin
        byte_s = 8'h00;
        case (idx_r)
            2'd0:    byte_s = pkt_r[7:0];
            2'd1:    byte_s = pkt_r[15:8];
            2'd2:    byte_s = pkt_r[23:16];
            default: byte_s = 8'h00;
        endcase
    end

    ps2_dev_byte_tx #(
        .CLK_HALF (CLK_HALF)
    ) u_byte_tx (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .data   (byte_s),
        .c_sync (c_sync_r),
        .c_low  (tx_c_low),
        .d_low  (tx_d_low),
        .done   (tx_done),
        .abort  (tx_abort)
    );

    assign ps2c = tx_c_low ? 1'b0 : 1'bz;
    assign ps2d = tx_d_low ? 1'b0 : 1'bz;

    assign ready      = ready_r;
    assign done_tick  = done_r;
    assign retry_tick = retry_r;

endmodule

// File: tb/tb_ps2_mouse_dev_tx.sv
// Scoreboard bench: a host model with pull-ups decodes frames off the bus and
// compares them against packets predicted from the movement rules.
module tb_ps2_mouse_dev_tx;

    localparam int CLK_HALF = 4;
    localparam int IDLE_CYC = 6;
    localparam int GAP_CYC  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] xm = 10'd0;
    logic [9:0] ym = 10'd0;
    logic [2:0] btnm = 3'd0;
    logic       wr_pkt = 1'b0;
    logic       ready, done_tick, retry_tick;
    logic       host_c = 1'b0;
    logic       host_d = 1'b0;
    wire        ps2c, ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = host_c ? 1'b0 : 1'bz;
    assign ps2d = host_d ? 1'b0 : 1'bz;

    ps2_mouse_dev_tx #(
        .CLK_HALF (CLK_HALF),
        .IDLE_CYC (IDLE_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .xm         (xm),
        .ym         (ym),
        .btnm       (btnm),
        .wr_pkt     (wr_pkt),
        .ready      (ready),
        .done_tick  (done_tick),
        .retry_tick (retry_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [23:0] exp_q[$];
    int pkt_pos = 0;
    int nbits = 0;
    int n_done = 0;
    int n_retry = 0;
    logic [10:0] shreg;
    logic prev_c = 1'b1;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Reference: saturate with plain integer arithmetic, then lay out the bytes.
    function automatic logic [23:0] model(input int x, input int y, input logic [2:0] b);
        int xs, ys;
        logic xo, yo;
        logic [7:0] b0, b1, b2;
        xs = x; xo = 1'b0;
        ys = y; yo = 1'b0;
        if (xs > 255) begin xs = 255; xo = 1'b1; end
        else if (xs < -256) begin xs = -256; xo = 1'b1; end
        if (ys > 255) begin ys = 255; yo = 1'b1; end
        else if (ys < -256) begin ys = -256; yo = 1'b1; end
        b0 = {yo, xo, logic'(ys < 0), logic'(xs < 0), 1'b1, b};
        b1 = 8'((xs + 512) % 256);
        b2 = 8'((ys + 512) % 256);
        return {b2, b1, b0};
    endfunction

    // Monitor: decode device frames on falling ps2c and score them.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                pkt_pos = 0;
                nbits = 0;
            end else begin
                if (retry_tick) begin
                    n_retry++;
                    check("retry_releases_data", int'(ps2d === 1'b1), 1);
                    pkt_pos = 0;
                    nbits = 0;
                end
                if (prev_c === 1'b1 && ps2c === 1'b0 && !host_c) begin
                    shreg[nbits] = (ps2d === 1'b0) ? 1'b0 : 1'b1;
                    nbits++;
                    if (nbits == 11) begin
                        nbits = 0;
                        check("start_bit", int'(shreg[0]), 0);
                        check("stop_bit", int'(shreg[10]), 1);
                        check("odd_parity", int'(^shreg[9:1]), 1);
                        if (exp_q.size() == 0 || pkt_pos > 2) begin
                            check("unexpected_byte", int'(shreg[8:1]), -1);
                        end else begin
                            logic [23:0] e;
                            e = exp_q[0];
                            check($sformatf("byte%0d", pkt_pos), int'(shreg[8:1]),
                                  int'(e[8*pkt_pos +: 8]));
                        end
                        pkt_pos++;
                    end
                end
                if (done_tick) begin
                    n_done++;
                    check("bytes_before_done", pkt_pos, 3);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    else check("done_without_packet", exp_q.size(), 1);
                    pkt_pos = 0;
                end
            end
            prev_c = (ps2c === 1'b0) ? 1'b0 : 1'b1;
        end
    end

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 5000) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic send(input int x, input int y, input logic [2:0] b);
        wait_ready("send_ready");
        xm = 10'(x); ym = 10'(y); btnm = b; wr_pkt = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, b));
        #1 wr_pkt = 1'b0;
    endtask

    task automatic run_pkt(input string name, input int x, input int y, input logic [2:0] b);
        int d0;
        d0 = n_done;
        send(x, y, b);
        wait_ready(name);
        check({name, "_done_once"}, n_done - d0, 1);
    endtask

    task automatic wait_bits(input int pos, input int bits);
        int k;
        k = 0;
        while (!(pkt_pos == pos && nbits == bits) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 3000) check("wait_bits_timeout", 0, 1);
    endtask

    initial begin
        int d0, r0, k, lowseen;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_ready", int'(ready), 1);
        check("reset_ps2c", int'(ps2c === 1'b1), 1);
        check("reset_ps2d", int'(ps2d === 1'b1), 1);
        check("reset_done", int'(done_tick), 0);
        check("reset_retry", int'(retry_tick), 0);

        run_pkt("basic", 5, -3, 3'b001);
        run_pkt("saturate", 300, -400, 3'b110);
        run_pkt("sat_edges", 255, -256, 3'b111);
        run_pkt("sat_edges2", 256, -257, 3'b000);

        // Host inhibit during data bit 4 of byte1.
        d0 = n_done; r0 = n_retry;
        send(-100, 77, 3'b010);
        wait_bits(1, 5);
        host_c = 1'b1;
        repeat (20) @(posedge clk);
        #1 host_c = 1'b0;
        wait_ready("inhibit");
        check("inhibit_retry_once", n_retry - r0, 1);
        check("inhibit_done_once", n_done - d0, 1);

        // Data held low before the first byte.
        host_d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(12, 34, 3'b100);
        lowseen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ps2c === 1'b0) lowseen++;
        end
        host_d = 1'b0;
        k = 0;
        while (ps2c !== 1'b0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("dlow_no_clock", lowseen, 0);
        check("dlow_wait_ok", int'(k >= IDLE_CYC + CLK_HALF && k < 200), 1);
        wait_ready("dlow");

        // Second request mid-packet must be ignored.
        d0 = n_done;
        send(-20, 40, 3'b011);
        repeat (50) @(posedge clk);
        #1;
        check("busy_not_ready", int'(ready), 0);
        xm = 10'd99; ym = 10'd99; btnm = 3'b101; wr_pkt = 1'b1;
        @(posedge clk); #1 wr_pkt = 1'b0;
        wait_ready("ignore");
        check("ignore_done_once", n_done - d0, 1);
        check("ignore_queue_empty", exp_q.size(), 0);

        // Reset during byte1.
        send(1, 2, 3'b001);
        wait_bits(1, 3);
        d0 = n_done;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_ps2c", int'(ps2c === 1'b1), 1);
        check("midreset_ps2d", int'(ps2d === 1'b1), 1);
        check("midreset_ready", int'(ready), 1);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("midreset_no_done", n_done - d0, 0);
        run_pkt("after_reset", -7, 8, 3'b010);

        for (int i = 0; i < 6; i++) begin
            run_pkt("random", int'($urandom_range(0, 1023)) - 512,
                    int'($urandom_range(0, 1023)) - 512, 3'($urandom_range(0, 7)));
        end

        repeat (5) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
